// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter that shares one FIFO write port among
//               N_REQ valid/ready packet streams.  The grant is locked to a
//               single requester until its packet ends or MAX_BURST beats
//               have been written, so packets never interleave.
// Ports       : clk, rst           - write-domain clock, async active-high reset
//               req_valid/_data/_last/_ready - per-requester beat streams,
//                                   requester i data at [i*DATA_W +: DATA_W]
//               full               - FIFO full flag (gates writes combinationally)
//               w_en, w_data       - FIFO write port
//               grant_id           - current or last granted requester
//               busy               - high while a grant is held
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
   parameter int DATA_W    = 32,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 8,
   localparam int IDW      = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    full,
   output logic                    w_en,
   output logic [DATA_W-1:0]       w_data,
   output logic [IDW-1:0]          grant_id,
   output logic                    busy
);

   localparam int              CNT_W      = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [IDW:0]    N_REQ_W    = (IDW + 1)'(N_REQ);
   localparam logic [IDW-1:0]  LAST_ID    = IDW'(N_REQ - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } state_t;

   state_t           state_q,  state_d;
   logic [IDW-1:0]   grant_q,  grant_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   logic             arb_found;
   logic [IDW-1:0]   arb_idx;
   logic [IDW-1:0]   next_id;
   logic             release_beat;

   // ------------------------------------------------------------------------
   // Unpack the flat data bus so the output mux is a plain array index.
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] data_arr [N_REQ];

   generate
      for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
         assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Round-robin scan: first valid requester starting at rr_ptr, wrapping.
   // The sum rr_ptr + i is below 2*N_REQ, so a single conditional subtract
   // is enough to reduce it modulo N_REQ for any N_REQ.
   // ------------------------------------------------------------------------
   always_comb begin
      logic [IDW:0] cand;
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, rr_ptr_q} + (IDW + 1)'(i);
         if (cand >= N_REQ_W) begin
            cand = cand - N_REQ_W;
         end
         if (!arb_found && req_valid[cand[IDW-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = cand[IDW-1:0];
         end
      end
   end

   assign next_id = (grant_q == LAST_ID) ? '0 : grant_q + IDW'(1);

   // ------------------------------------------------------------------------
   // Outputs.  full gates w_en/req_ready combinationally; nothing is accepted
   // outside LOCK.
   // ------------------------------------------------------------------------
   always_comb begin
      busy      = 1'b0;
      w_en      = 1'b0;
      req_ready = '0;
      if (state_q == S_LOCK) begin
         busy               = 1'b1;
         req_ready[grant_q] = !full;
         w_en               = req_valid[grant_q] && !full;
      end
   end

   assign w_data   = data_arr[grant_q];
   assign grant_id = grant_q;

   // A grant ends on the beat carrying last, or on the beat that completes
   // MAX_BURST; a cut packet continues at this requester's next grant.
   assign release_beat = req_last[grant_q] || (cnt_q == BURST_LAST);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               grant_d = arb_idx;
               cnt_d   = '0;
               state_d = S_LOCK;
            end
         end
         S_LOCK: begin
            if (w_en) begin
               if (release_beat) begin
                  state_d  = S_IDLE;
                  rr_ptr_d = next_id;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter.  Per-requester
//               source queues feed the DUT; every beat offered is also pushed
//               to that requester's expected queue and popped when the DUT
//               writes it.  Grant order and burst lengths are logged and
//               compared against hand-derived sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

   localparam int DW = 32;
   localparam int NR = 4;
   localparam int MB = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_last;
   logic [NR-1:0]     req_ready;
   logic              full;
   logic              w_en;
   logic [DW-1:0]     w_data;
   logic [1:0]        grant_id;
   logic              busy;

   fifo_wr_arbiter #(.DATA_W(DW), .N_REQ(NR), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .full      (full),
      .w_en      (w_en),
      .w_data    (w_data),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } beat_t;

   beat_t       src_q [NR][$];
   logic [31:0] exp_q [NR][$];
   logic [NR-1:0] stall;
   logic          full_t;

   int n_tests = 0;
   int n_fail  = 0;
   int grant_log[$];
   int gap_log[$];
   int burst_log[$];
   logic prev_busy;
   int idle_run;
   int cur_beats;
   int wr_count;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_log(input string tag, input int got[$], input int exp[$]);
      check_val({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         check_val($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
      end
   endtask

   task automatic push_pkt(input int r, input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         beat_t b;
         b.d = base + 32'(k);
         b.l = (k == n - 1);
         src_q[r].push_back(b);
         exp_q[r].push_back(b.d);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (src_q[i].size() > 0 && !stall[i]) begin
            req_valid[i]          = 1'b1;
            req_data[i*DW +: DW]  = src_q[i][0].d;
            req_last[i]           = src_q[i][0].l;
         end else begin
            req_valid[i]          = 1'b0;
            req_data[i*DW +: DW]  = 32'hDEAD0000 | 32'(i);
            req_last[i]           = 1'b0;
         end
      end
      full = full_t;
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NR; i++) begin
         if (src_q[i].size() > 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // One clock: drive at the falling edge, observe 1 ns later (values hold
   // until the next rising edge), score writes and retire accepted beats.
   task automatic cycle();
      logic [NR-1:0] acc;
      @(negedge clk);
      drive();
      #1;
      if (busy && !prev_busy) begin
         grant_log.push_back(int'(grant_id));
         gap_log.push_back(idle_run);
         idle_run = 0;
      end
      if (!busy) idle_run++;
      if (!busy && prev_busy) begin
         burst_log.push_back(cur_beats);
         cur_beats = 0;
      end
      prev_busy = busy;
      if (w_en) begin
         cur_beats++;
         wr_count++;
         check_val("wr_avail", 64'(exp_q[grant_id].size() > 0), 64'(1));
         if (exp_q[grant_id].size() > 0) begin
            check_val($sformatf("wdata_r%0d", grant_id), 64'(w_data), 64'(exp_q[grant_id].pop_front()));
         end
      end
      acc = req_valid & req_ready;
      check_val("handshake", 64'(acc), 64'(w_en ? (4'b0001 << grant_id) : 4'b0000));
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) void'(src_q[i].pop_front());
      end
   endtask

   task automatic run_until_idle(input int max_cyc);
      int  k;
      bit  done;
      k    = 0;
      done = 1'b0;
      while (!done && k < max_cyc) begin
         cycle();
         k++;
         done = all_empty() && !busy;
      end
      check_val("drain_timeout", 64'(done), 64'(1));
      for (int i = 0; i < NR; i++) begin
         check_val($sformatf("exp_empty_r%0d", i), 64'(exp_q[i].size()), 64'(0));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < NR; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      stall  = '0;
      full_t = 1'b0;
      drive();
      grant_log.delete();
      gap_log.delete();
      burst_log.delete();
      prev_busy = 1'b0;
      idle_run  = 0;
      cur_beats = 0;
      #1;
      check_val("rst_busy", 64'(busy), 64'(0));
      check_val("rst_wen", 64'(w_en), 64'(0));
      check_val("rst_ready", 64'(req_ready), 64'(0));
      check_val("rst_grant", 64'(grant_id), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e[$];
      int k;
      int start_wr;
      rst       = 1'b1;
      stall     = '0;
      full_t    = 1'b0;
      prev_busy = 1'b0;
      idle_run  = 0;
      cur_beats = 0;
      wr_count  = 0;
      drive();

      // ---------------- single packet from requester 2 ----------------
      do_reset();
      push_pkt(2, 3, 32'h0000_000A);
      cycle();
      check_val("t1_idle", 64'(busy), 64'(0));
      cycle();
      check_val("t1_busy", 64'(busy), 64'(1));
      check_val("t1_grant", 64'(grant_id), 64'(2));
      check_val("t1_wen0", 64'(w_en), 64'(1));
      cycle();
      check_val("t1_wen1", 64'(w_en), 64'(1));
      cycle();
      check_val("t1_wen2", 64'(w_en), 64'(1));
      cycle();
      check_val("t1_release", 64'(busy), 64'(0));
      // rr_ptr must now be 3: requester 3 beats requester 0
      grant_log.delete();
      push_pkt(0, 1, 32'h1000_0000);
      push_pkt(3, 1, 32'h1300_0000);
      run_until_idle(40);
      e = '{3, 0};
      check_log("t1_rr", grant_log, e);

      // ---------------- round-robin fairness ----------------
      do_reset();
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < NR; i++) begin
            push_pkt(i, 1, 32'h2000_0000 | (32'(i) << 8) | 32'(p));
         end
      end
      run_until_idle(200);
      e = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
      check_log("t2_order", grant_log, e);
      for (int j = 1; j < gap_log.size(); j++) begin
         check_val($sformatf("t2_gap[%0d]", j), 64'(gap_log[j]), 64'(1));
      end

      // ---------------- burst limit ----------------
      do_reset();
      push_pkt(1, 20, 32'h3100_0000);
      push_pkt(3, 3, 32'h3300_0000);
      run_until_idle(200);
      e = '{1, 3, 1, 1};
      check_log("t3_order", grant_log, e);
      e = '{8, 3, 8, 4};
      check_log("t3_burst", burst_log, e);

      // ---------------- backpressure ----------------
      do_reset();
      push_pkt(0, 6, 32'h4000_0000);
      cycle();
      cycle();
      check_val("t4_wen_a", 64'(w_en), 64'(1));
      cycle();
      check_val("t4_wen_b", 64'(w_en), 64'(1));
      full_t = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cycle();
         check_val($sformatf("t4_full_wen%0d", c), 64'(w_en), 64'(0));
         check_val($sformatf("t4_full_rdy%0d", c), 64'(req_ready), 64'(0));
         check_val($sformatf("t4_full_busy%0d", c), 64'(busy), 64'(1));
         check_val($sformatf("t4_full_gnt%0d", c), 64'(grant_id), 64'(0));
      end
      full_t = 1'b0;
      cycle();
      check_val("t4_resume", 64'(w_en), 64'(1));
      run_until_idle(40);
      e = '{6};
      check_log("t4_burst", burst_log, e);

      // ---------------- requester stall ----------------
      do_reset();
      push_pkt(2, 6, 32'h5000_0000);
      cycle();
      cycle();
      check_val("t5_grant", 64'(grant_id), 64'(2));
      check_val("t5_wen", 64'(w_en), 64'(1));
      push_pkt(0, 1, 32'h5A00_0000);
      cycle();
      stall[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cycle();
         check_val($sformatf("t5_stall_wen%0d", c), 64'(w_en), 64'(0));
         check_val($sformatf("t5_stall_busy%0d", c), 64'(busy), 64'(1));
         check_val($sformatf("t5_stall_gnt%0d", c), 64'(grant_id), 64'(2));
      end
      stall[2] = 1'b0;
      run_until_idle(60);
      e = '{2, 0};
      check_log("t5_order", grant_log, e);
      e = '{6, 1};
      check_log("t5_burst", burst_log, e);

      // ---------------- reset mid-burst ----------------
      do_reset();
      push_pkt(2, 1, 32'h6200_0000);
      run_until_idle(20);
      grant_log.delete();
      burst_log.delete();
      push_pkt(1, 8, 32'h6100_0000);
      start_wr = wr_count;
      k = 0;
      while (wr_count - start_wr < 3 && k < 20) begin
         cycle();
         k++;
      end
      check_val("t6_three_beats", 64'(wr_count - start_wr), 64'(3));
      @(negedge clk);
      drive();
      #1;
      check_val("t6_pre_wen", 64'(w_en), 64'(1));
      check_val("t6_pre_grant", 64'(grant_id), 64'(1));
      rst = 1'b1;
      #1;
      check_val("t6_rst_wen", 64'(w_en), 64'(0));
      check_val("t6_rst_busy", 64'(busy), 64'(0));
      check_val("t6_rst_ready", 64'(req_ready), 64'(0));
      check_val("t6_rst_grant", 64'(grant_id), 64'(0));
      check_val("t6_rst_wdata", 64'(w_data), 64'(32'hDEAD0000));
      @(posedge clk);
      #1;
      check_val("t6_edge_wen", 64'(w_en), 64'(0));
      push_pkt(0, 1, 32'h6000_0000);
      push_pkt(3, 1, 32'h6300_0000);
      drive();
      prev_busy = 1'b0;
      idle_run  = 0;
      cur_beats = 0;
      grant_log.delete();
      burst_log.delete();
      @(negedge clk);
      rst = 1'b0;
      run_until_idle(60);
      e = '{0, 1, 3};
      check_log("t6_order", grant_log, e);
      e = '{1, 5, 1};
      check_log("t6_burst", burst_log, e);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one FIFO write interface among `N_REQ` requesters in the FIFO's write-clock domain. Each requester offers a valid/ready packet stream. The arbiter locks the grant to one requester until that requester's packet ends or a burst limit is reached, so beats from different requesters never interleave within a packet. It drives the FIFO's `w_en`/`w_data` and honours its registered `full` flag.

## Interface
- `DATA_W`, 32: beat width; must match the FIFO `DATA_W`.
- `N_REQ`, 4: number of requesters, ≥2. `IDW = $clog2(N_REQ)`.
- `MAX_BURST`, 8: maximum beats per grant, ≥1. Beat counter width is `$clog2(MAX_BURST+1)`.

- `clk`  in  1  write-domain clock (same clock as the FIFO `w_clk`).
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester beat valid.
- `req_data`  in  N_REQ*DATA_W  requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_last`  in  N_REQ  marks the final beat of a packet.
- `req_ready`  out  N_REQ  the beat is accepted on a clock edge where `req_valid[i] && req_ready[i]`.
- `full`  in  1  FIFO full flag.
- `w_en`  out  1  FIFO write enable.
- `w_data`  out  DATA_W  FIFO write data.
- `grant_id`  out  IDW  current or last granted requester.
- `busy`  out  1  high while a grant is held (state LOCK).

## Operation
- State machine has two states: IDLE and LOCK. Registers are `state`, `grant_id`, `rr_ptr` (IDW bits) and `beat_cnt`.
- **IDLE:**
  - If any `req_valid` is high, select the first set bit scanning `rr_ptr, rr_ptr+1, …` modulo `N_REQ`.
  - Register the winner into `grant_id`, clear `beat_cnt`, and go to LOCK.
  - If no `req_valid` is high, remain in IDLE.
  - `req_valid` levels in IDLE are sampled only for arbitration; no beat is accepted in IDLE.
- **LOCK, combinational outputs:**
  - `req_ready[grant_id] = !full`.
  - All other `req_ready` bits are 0.
  - `w_en = req_valid[grant_id] && !full`.
  - `w_data = req_data[grant_id]`.
- **LOCK, accepted beat:** an accepted beat is a clock edge with `w_en = 1`. On each accepted beat `beat_cnt` increments.
- **Release:** on an accepted beat where `req_last[grant_id] = 1` or `beat_cnt == MAX_BURST-1`:
  - go to IDLE;
  - set `rr_ptr = (grant_id + 1) mod N_REQ`, wrapping from `N_REQ-1` to 0;
  - `beat_cnt` returns to 0.
- A burst cut by `MAX_BURST` resumes the same packet at that requester's next grant. Packet boundaries are the requester's concern.
- **Stalls in LOCK:**
  - If `req_valid[grant_id]` drops, LOCK is held with `w_en = 0`. There is no timeout.
  - If `full = 1`, LOCK is held with `w_en = 0` and all `req_ready` low.
- **Outputs in IDLE:** `w_en = 0` and all `req_ready = 0`. `w_data` still follows `req_data[grant_id]`; its value is don't-care whenever `w_en = 0`.
- Non-granted requesters may change `req_valid`/`req_data` freely. Granted requesters must hold data stable while valid and not ready.
- **Reset (asserts asynchronously):**
  - `state` goes to IDLE; `grant_id`, `rr_ptr` and `beat_cnt` go to 0.
  - `busy`, `w_en` and `req_ready` go to 0 immediately.
  - `w_data` reflects `req_data[0]`.
  - Reset asserted mid-burst abandons the burst; no beat is written on the reset edge.
  - Deassertion is synchronous to `clk` and is handled externally.

## Timing
- **Arbitration latency:** `req_valid` high before edge E0 in IDLE → `busy`/`grant_id` update at E0. `w_en` can be high in the cycle after E0, and the first write lands at E1.
- **Throughput:** one beat per cycle while `!full` and valid.
- **Turnaround:** the release edge leads to an IDLE cycle, then the next grant. There is exactly one dead cycle between grants.
- **Path from `full`:** `full` → `w_en`/`req_ready` is combinational with no extra register. The FIFO's registered `full` asserts the cycle after the filling write, so combining it with the FIFO's own `!full` gate guarantees no overflow.
- **Simultaneous events:** release and a new `req_valid` on the same edge are resolved in the following IDLE cycle, using the updated `rr_ptr`.

## Test plan
- **Single packet:** after reset, only req 2 sends 3 beats (0xA, 0xB, 0xC; last on 0xC).
  - Required: `grant_id = 2` one edge after valid; 3 consecutive `w_en` cycles with data in that order.
  - Required after the burst: `busy` falls at the release edge and `rr_ptr = 3`.
- **Round-robin fairness:** all 4 requesters send continuous 1-beat packets.
  - Required grant order: 0, 1, 2, 3, 0, …
  - Required: exactly one IDLE cycle between grants and no repeat grant while others are waiting.
- **Burst limit:** req 1 streams 20 beats with `last` on beat 20 while req 3 is also valid, `MAX_BURST = 8`.
  - Required: req 1 gets 8 beats, then req 3 is granted, then req 1 resumes.
  - Required: req 1 data is written in order with no loss.
- **Backpressure:** `full` held high for 5 cycles mid-burst.
  - Required: `w_en = 0` and `req_ready = 0` during those cycles.
  - Required: the grant is held and the pending beat is written on the first cycle after `full` drops.
- **Requester stall:** the granted requester drops valid for 3 cycles mid-packet while req 0 is valid.
  - Required: the grant is kept with no writes, then the packet resumes.
  - Required: req 0 is granted only after the last beat.
- **Reset mid-burst:** `rst` pulses during the beat-4 cycle.
  - Required: `w_en` goes low immediately and no write occurs at that edge.
  - Required after reset: `busy = 0`, `grant_id = 0`, and arbitration restarts from `rr_ptr = 0`.
